uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter EOL_CHAR, default 8'h0D, the ASCII byte that terminates a command line.
REQ-002 SHALL have parameter IGN_CHAR, default 8'h0A, an ASCII byte that is silently ignored in IDLE, so CR/LF line endings work.
REQ-003 Port: clk  input  1  single clock; all logic is posedge clk.
REQ-004 Port: i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: i_rx_dv  input  1  one-cycle strobe; a received byte is present.
REQ-006 Port: i_rx_byte  input  8  received byte, valid only when i_rx_dv=1.
REQ-007 Port: o_cmd_valid  output  1  a parsed command is pending.
REQ-008 Port: i_cmd_ready  input  1  consumer accepts the pending command.
REQ-009 Port: o_cmd_wr  output  1  1=write command, 0=read command.
REQ-010 Port: o_cmd_addr  output  8  parsed address.
REQ-011 Port: o_cmd_data  output  8  parsed write data; 8'h00 for reads.
REQ-012 Port: o_err  output  1  one-cycle error strobe.
REQ-013 Port: o_err_code  output  2  error code: 0 overflow, 1 bad opcode, 2 bad hex digit, 3 bad length; held until the next o_err.

Function
REQ-014 Command grammar, no spaces: 'W'/'w' + 2 hex digits (addr) + 2 hex digits (data) + EOL; 'R'/'r' + 2 hex digits (addr) + EOL; hex digits are 0-9, A-F, a-f; the high nibble is first.
REQ-015 FSM states: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WAIT_EOL, DISCARD; the FSM advances only on cycles with i_rx_dv=1.
REQ-016 IDLE: 'W'/'w' -> ADDR_HI with wr=1; 'R'/'r' -> ADDR_HI with wr=0; EOL_CHAR or IGN_CHAR -> stay in IDLE, no error; any other byte -> o_err code 1, go to DISCARD.
REQ-017 ADDR_HI -> ADDR_LO -> (wr ? DATA_HI -> DATA_LO : done) -> WAIT_EOL; each step on a valid hex digit; a non-hex byte -> code 2, DISCARD; EOL before all digits are received -> code 3, IDLE.
REQ-018 WAIT_EOL: EOL_CHAR -> command complete, IDLE; any other byte -> code 3, DISCARD.
REQ-019 DISCARD: drop every byte until EOL_CHAR, then go to IDLE; no further errors are raised within the same line.
REQ-020 On command completion, the output registers SHALL load and o_cmd_valid SHALL assert on the cycle after the EOL strobe (1-cycle latency).
REQ-021 Handshake: o_cmd_valid SHALL stay high and o_cmd_wr/addr/data SHALL stay stable until a cycle with o_cmd_valid=1 and i_cmd_ready=1; o_cmd_valid SHALL deassert the cycle after that unless REQ-022 applies.
REQ-022 Simultaneous event: if a new command completes on the same cycle as the pending one is accepted, the new command SHALL load and o_cmd_valid SHALL remain 1.
REQ-023 If a new command completes while one is pending and not accepted, the new command SHALL be dropped, the pending one SHALL be kept, and o_err SHALL pulse with code 0.
REQ-024 o_err SHALL assert one cycle after the offending byte strobe.
REQ-025 The parser SHALL never stall input; parsing continues while o_cmd_valid is pending.
REQ-026 o_cmd_data SHALL be 8'h00 for read commands.

Reset
REQ-027 When i_rst_n=0 at a clock edge: FSM -> IDLE; o_cmd_valid=0, o_cmd_wr=0, o_cmd_addr=0, o_cmd_data=0, o_err=0, o_err_code=0; nibble accumulators cleared.
REQ-028 Reset mid-line or with a command pending SHALL discard both; the first byte after reset is parsed as the start of a line.

Structure
REQ-029 Shared header uart_cmd_defs.vh SHALL hold the ASCII constants ('W','w','R','r', CR, LF), the error-code constants, and the FSM state encodings.
REQ-030 Combinational sub-module ascii_hex_decode SHALL provide 8-bit ASCII in and 4-bit nibble out plus a 1-bit is_hex flag; it is instantiated once.
REQ-031 uart_cmd_parser SHALL connect directly to the UART receiver's o_rx_dv/o_rx_byte outputs with no added buffering.

Verification
REQ-032 Input "W1Aff\r", i_cmd_ready=1 -> one o_cmd_valid pulse, wr=1, addr=8'h1A, data=8'hFF, no o_err.
REQ-033 Input "r7C\r\n", i_cmd_ready=0 for 20 cycles -> o_cmd_valid held 20+ cycles, wr=0, addr=8'h7C, data=8'h00; the LF causes no error.
REQ-034 Input "X12\r" then "R05\r" -> o_err code 1 after 'X', no command from the first line, then a read of addr=8'h05.
REQ-035 Input "W1G34\r" -> code 2 on 'G'; "R123\r" -> code 3 on '3'; "W12\r" -> code 3 on CR; only one error per line.
REQ-036 Input "R01\r" held pending (ready=0), then "R02\r" -> code 0, addr stays 8'h01; repeat with ready=1 on the cycle "R02" completes -> addr becomes 8'h02 and valid stays 1.
REQ-037 Assert i_rst_n=0 after "W3" -> all outputs zero; then "R44\r" -> read addr=8'h44 with no error.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: ASCII constants, error codes
// and FSM state encodings.
package uart_cmd_parser_pkg;

  localparam logic [7:0] CH_W_UP = 8'h57;
  localparam logic [7:0] CH_W_LO = 8'h77;
  localparam logic [7:0] CH_R_UP = 8'h52;
  localparam logic [7:0] CH_R_LO = 8'h72;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  localparam logic [1:0] ERR_OVERFLOW = 2'd0;
  localparam logic [1:0] ERR_OPCODE   = 2'd1;
  localparam logic [1:0] ERR_HEX      = 2'd2;
  localparam logic [1:0] ERR_LEN      = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR_HI  = 3'd1,
    ST_ADDR_LO  = 3'd2,
    ST_DATA_HI  = 3'd3,
    ST_DATA_LO  = 3'd4,
    ST_WAIT_EOL = 3'd5,
    ST_DISCARD  = 3'd6
  } state_t;

endpackage

// File: rtl/uart_cmd_parser_hex.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f to a 4-bit nibble.
module ascii_hex_decode (
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       is_hex
);

  always_comb begin
    nibble = 4'h0;
    is_hex = 1'b0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      nibble = ascii[3:0];
      is_hex = 1'b1;
    end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                 (ascii >= 8'h61 && ascii <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      nibble = ascii[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "Waadd<EOL>" / "Raa<EOL>" lines from a UART byte stream into a
// valid/ready command port with one-cycle error strobes.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] EOL_CHAR = CH_CR,
  parameter logic [7:0] IGN_CHAR = CH_LF
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_cmd_valid,
  input  logic       i_cmd_ready,
  output logic       o_cmd_wr,
  output logic [7:0] o_cmd_addr,
  output logic [7:0] o_cmd_data,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  state_t     state;
  logic       wr_acc;
  logic [7:0] addr_acc;
  logic [7:0] data_acc;
  logic [3:0] nib;
  logic       is_hex;
  logic       is_eol;

  ascii_hex_decode u_hex (
    .ascii  (i_rx_byte),
    .nibble (nib),
    .is_hex (is_hex)
  );

  assign is_eol = (i_rx_byte == EOL_CHAR);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      wr_acc      <= 1'b0;
      addr_acc    <= 8'h00;
      data_acc    <= 8'h00;
      o_cmd_valid <= 1'b0;
      o_cmd_wr    <= 1'b0;
      o_cmd_addr  <= 8'h00;
      o_cmd_data  <= 8'h00;
      o_err       <= 1'b0;
      o_err_code  <= ERR_OVERFLOW;
    end else begin
      o_err <= 1'b0;
      if (o_cmd_valid && i_cmd_ready)
        o_cmd_valid <= 1'b0;

      if (i_rx_dv) begin
        unique case (state)
          ST_IDLE: begin
            if (i_rx_byte == CH_W_UP || i_rx_byte == CH_W_LO ||
                i_rx_byte == CH_R_UP || i_rx_byte == CH_R_LO) begin
              wr_acc   <= (i_rx_byte == CH_W_UP || i_rx_byte == CH_W_LO);
              addr_acc <= 8'h00;
              data_acc <= 8'h00;
              state    <= ST_ADDR_HI;
            end else if (!(is_eol || i_rx_byte == IGN_CHAR)) begin
              o_err      <= 1'b1;
              o_err_code <= ERR_OPCODE;
              state      <= ST_DISCARD;
            end
          end
          ST_ADDR_HI, ST_ADDR_LO, ST_DATA_HI, ST_DATA_LO: begin
            // A short line ends here, so go straight back to IDLE
            if (is_eol) begin
              o_err      <= 1'b1;
              o_err_code <= ERR_LEN;
              state      <= ST_IDLE;
            end else if (!is_hex) begin
              o_err      <= 1'b1;
              o_err_code <= ERR_HEX;
              state      <= ST_DISCARD;
            end else begin
              case (state)
                ST_ADDR_HI: begin
                  addr_acc[7:4] <= nib;
                  state         <= ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                  addr_acc[3:0] <= nib;
                  state         <= wr_acc ? ST_DATA_HI : ST_WAIT_EOL;
                end
                ST_DATA_HI: begin
                  data_acc[7:4] <= nib;
                  state         <= ST_DATA_LO;
                end
                default: begin
                  data_acc[3:0] <= nib;
                  state         <= ST_WAIT_EOL;
                end
              endcase
            end
          end
          ST_WAIT_EOL: begin
            if (is_eol) begin
              state <= ST_IDLE;
              // Load only if the slot is free or is being freed this cycle
              if (!o_cmd_valid || i_cmd_ready) begin
                o_cmd_valid <= 1'b1;
                o_cmd_wr    <= wr_acc;
                o_cmd_addr  <= addr_acc;
                o_cmd_data  <= wr_acc ? data_acc : 8'h00;
              end else begin
                o_err      <= 1'b1;
                o_err_code <= ERR_OVERFLOW;
              end
            end else begin
              o_err      <= 1'b1;
              o_err_code <= ERR_LEN;
              state      <= ST_DISCARD;
            end
          end
          ST_DISCARD: begin
            if (is_eol)
              state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: table-driven single lines plus
// hand-written handshake, overflow and reset sequences.
module tb_uart_cmd_parser;
  import uart_cmd_parser_pkg::*;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       o_cmd_valid;
  logic       i_cmd_ready;
  logic       o_cmd_wr;
  logic [7:0] o_cmd_addr;
  logic [7:0] o_cmd_data;
  logic       o_err;
  logic [1:0] o_err_code;

  uart_cmd_parser dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_rx_dv     (i_rx_dv),
    .i_rx_byte   (i_rx_byte),
    .o_cmd_valid (o_cmd_valid),
    .i_cmd_ready (i_cmd_ready),
    .o_cmd_wr    (o_cmd_wr),
    .o_cmd_addr  (o_cmd_addr),
    .o_cmd_data  (o_cmd_data),
    .o_err       (o_err),
    .o_err_code  (o_err_code)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Observed activity, sampled on the falling edge
  int         err_cnt = 0;
  logic [1:0] last_code = 2'd0;
  int         acc_cnt = 0;
  int         vld_cycles = 0;
  logic       last_wr = 1'b0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    if (o_err) begin
      err_cnt   = err_cnt + 1;
      last_code = o_err_code;
    end
    if (o_cmd_valid) vld_cycles = vld_cycles + 1;
    if (o_cmd_valid && i_cmd_ready) begin
      acc_cnt   = acc_cnt + 1;
      last_wr   = o_cmd_wr;
      last_addr = o_cmd_addr;
      last_data = o_cmd_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the strobe edge, so registered responses are visible
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    @(posedge clk); #1;
    i_rx_dv   = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  typedef struct {
    string      line;
    int         ncmd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         nerr;
    logic [1:0] code;
  } vec_t;

  vec_t vecs[9];

  int e0, c0, v0, hold;

  initial begin
    vecs[0] = '{"W1Aff\015",   1, 1'b1, 8'h1A, 8'hFF, 0, 2'd0};
    vecs[1] = '{"X12\015",     0, 1'b0, 8'h00, 8'h00, 1, 2'd1};
    vecs[2] = '{"R05\015",     1, 1'b0, 8'h05, 8'h00, 0, 2'd0};
    vecs[3] = '{"W1G34\015",   0, 1'b0, 8'h00, 8'h00, 1, 2'd2};
    vecs[4] = '{"R123\015",    0, 1'b0, 8'h00, 8'h00, 1, 2'd3};
    vecs[5] = '{"W12\015",     0, 1'b0, 8'h00, 8'h00, 1, 2'd3};
    vecs[6] = '{"\012\015\012", 0, 1'b0, 8'h00, 8'h00, 0, 2'd0};
    vecs[7] = '{"wabCD\015",   1, 1'b1, 8'hAB, 8'hCD, 0, 2'd0};
    vecs[8] = '{"Rz9z\015",    0, 1'b0, 8'h00, 8'h00, 1, 2'd2};

    i_rst_n     = 1'b0;
    i_rx_dv     = 1'b0;
    i_rx_byte   = 8'h00;
    i_cmd_ready = 1'b1;
    idle(3);
    check("reset_outputs", {o_cmd_valid, o_cmd_wr, o_cmd_addr, o_cmd_data, o_err, o_err_code}, 32'h0);
    i_rst_n = 1'b1;
    idle(2);

    // Table: one line per record with the consumer always ready
    for (int i = 0; i < 9; i++) begin
      e0 = err_cnt; c0 = acc_cnt; v0 = vld_cycles;
      send_line(vecs[i].line);
      idle(4);
      check($sformatf("v%0d_cmds", i), acc_cnt - c0, vecs[i].ncmd);
      check($sformatf("v%0d_valid_cycles", i), vld_cycles - v0, vecs[i].ncmd);
      check($sformatf("v%0d_errs", i), err_cnt - e0, vecs[i].nerr);
      if (vecs[i].ncmd > 0) begin
        check($sformatf("v%0d_wr", i), last_wr, vecs[i].wr);
        check($sformatf("v%0d_addr", i), last_addr, vecs[i].addr);
        check($sformatf("v%0d_data", i), last_data, vecs[i].data);
      end
      if (vecs[i].nerr > 0)
        check($sformatf("v%0d_code", i), last_code, vecs[i].code);
    end

    // Error strobe latency and pulse width
    send_byte("X");
    check("err_latency", {o_err, o_err_code}, {1'b1, 2'd1});
    idle(1);
    check("err_pulse_width", o_err, 1'b0);
    send_line("12\015");
    idle(2);

    // Read held pending for 20+ cycles; LF afterwards is ignored
    i_cmd_ready = 1'b0;
    e0 = err_cnt;
    send_line("r7C");
    send_byte(8'h0D);
    check("valid_latency", o_cmd_valid, 1'b1);
    send_byte(8'h0A);
    hold = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_cmd_valid) hold++;
    end
    check("hold_cycles", hold, 20);
    check("hold_fields", {o_cmd_wr, o_cmd_addr, o_cmd_data}, {1'b0, 8'h7C, 8'h00});
    check("hold_no_err", err_cnt - e0, 0);
    i_cmd_ready = 1'b1;
    idle(1);
    check("valid_drop_after_accept", o_cmd_valid, 1'b0);

    // Overflow: second command dropped while the first is pending
    i_cmd_ready = 1'b0;
    send_line("R01\015");
    e0 = err_cnt;
    send_line("R02");
    send_byte(8'h0D);
    check("overflow_err", {o_err, o_err_code}, {1'b1, 2'd0});
    idle(2);
    check("overflow_keeps", {o_cmd_valid, o_cmd_addr}, {1'b1, 8'h01});
    check("overflow_err_count", err_cnt - e0, 1);

    // Accept on the same cycle the next command completes
    send_line("R02");
    @(posedge clk); #1;
    i_rx_dv = 1'b1; i_rx_byte = 8'h0D; i_cmd_ready = 1'b1;
    @(posedge clk); #1;
    i_rx_dv = 1'b0; i_cmd_ready = 1'b0;
    check("simul_load", {o_cmd_valid, o_cmd_addr, o_err}, {1'b1, 8'h02, 1'b0});
    i_cmd_ready = 1'b1;
    idle(2);
    check("simul_drained", o_cmd_valid, 1'b0);

    // Reset mid-line with a command pending
    i_cmd_ready = 1'b0;
    send_line("R11\015");
    send_line("W3");
    @(posedge clk); #1;
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    check("midline_reset", {o_cmd_valid, o_cmd_wr, o_cmd_addr, o_cmd_data, o_err, o_err_code}, 32'h0);
    i_rst_n = 1'b1;
    i_cmd_ready = 1'b1;
    e0 = err_cnt; c0 = acc_cnt;
    send_line("R44\015");
    idle(3);
    check("post_reset_cmds", acc_cnt - c0, 1);
    check("post_reset_fields", {last_wr, last_addr, last_data}, {1'b0, 8'h44, 8'h00});
    check("post_reset_no_err", err_cnt - e0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
